warp_issue_scheduler: RTL and testbench
=======================================

WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp contexts (power of two, 2..16); WID = log2(NUM_WARPS).
REQ-002 SHALL have parameter PC_WIDTH, default 8, per-warp program counter width.
REQ-003 SHALL have parameter NUM_THREADS, default 32, threads per warp and thread-mask width.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: launch_valid in 1; launch_warp in WID; launch_pc in PC_WIDTH; launch_mask in NUM_THREADS (start a warp).
REQ-006 SHALL have ports: mask_write_en in 1; mask_warp in WID; mask_in in NUM_THREADS (next-instruction thread mask from instruction buffer).
REQ-007 SHALL have ports: clear_valid in 1; clear_warp in WID; clear_mask in NUM_THREADS (LSU completion, releases threads).
REQ-008 SHALL have ports: done_valid in 1; done_warp in WID (warp exit).
REQ-009 SHALL have ports: issue_valid out 1; issue_ready in 1; issue_warp out WID; issue_pc out PC_WIDTH; issue_mask out NUM_THREADS.
REQ-010 SHALL have port active_warps out NUM_WARPS, bit w high when warp w is ACTIVE.

Function
REQ-011 SHALL hold per warp: state (IDLE/ACTIVE), pc, next_mask, pending mask (scoreboard).
REQ-012 launch_valid to an IDLE warp SHALL next cycle set ACTIVE, pc=launch_pc, next_mask=launch_mask, pending=0; launch to an ACTIVE warp SHALL be ignored.
REQ-013 mask_write_en SHALL update next_mask of an ACTIVE warp; ignored for IDLE; launch wins on same warp same cycle.
REQ-014 Warp eligible = ACTIVE and next_mask!=0 and (pending & next_mask)==0.
REQ-015 Output register SHALL load when empty or accepted (issue_valid&&issue_ready) this cycle; latency eligibility-to-issue_valid is 1 cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at last loaded warp+1, wrapping modulo NUM_WARPS; after reset search starts at warp 0.
REQ-017 On load, selected warp SHALL get pending|=next_mask and pc=pc+1 (wrap modulo 2^PC_WIDTH); output captures pre-increment pc.
REQ-018 issue_warp/issue_pc/issue_mask SHALL hold stable while issue_valid&&!issue_ready.
REQ-019 clear_valid SHALL set pending&=~clear_mask for clear_warp; clear and load on same warp same cycle: pending=(pending&~clear_mask)|next_mask.
REQ-020 A clear releasing a warp's threads SHALL allow that warp's load no earlier than the following cycle (no combinational clear-to-issue path).
REQ-021 done_valid to an ACTIVE warp SHALL set IDLE and pending=0; an already-loaded issue for that warp SHALL still be presented until accepted; done to IDLE ignored.
REQ-022 No eligible warp and output empty/accepted: issue_valid SHALL deassert next cycle.

Reset
REQ-023 On reset all warps SHALL be IDLE, pc=0, next_mask=0, pending=0; issue_valid=0, issue_warp=0, issue_pc=0, issue_mask=0, active_warps=0; RR pointer to warp 0.
REQ-024 Reset mid-handshake SHALL drop any held issue without acceptance; reset dominates all other inputs.

Configuration
REQ-025 With WARP_SCHED_PERF_EN defined SHALL add outputs issue_count (32) incremented per accepted issue and stall_count (32) incremented each cycle with >=1 ACTIVE warp and no eligible warp and issue_valid low; both wrap, reset to 0.
REQ-026 Without WARP_SCHED_PERF_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-027 Launch warps 0..3 pc=0x10,0x20,0x30,0x40 mask=0xFFFFFFFF, issue_ready=1, clear every issue 1 cycle later -> issues in order 0,1,2,3,0 with pc 0x10,0x20,0x30,0x40,0x11.
REQ-028 Warp 1 issued mask 0x0000FFFF, no clear, next_mask unchanged -> warp 1 never reissued; clear_mask 0x000000FF -> still stalled; clear 0x0000FF00 -> reissued 2 cycles after clear.
REQ-029 Hold issue_ready=0 for 5 cycles with warp 2 loaded -> issue_warp=2, pc, mask constant; release -> next warp loaded following cycle.
REQ-030 Launch warp 0 while ACTIVE with pc 0x77 -> ignored, pc continues; done_warp=0 then launch pc 0x77 -> next issue pc 0x77.
REQ-031 Only warp 3 active, pc=0xFF, instant clears -> issue_pc 0xFF then 0x00.
REQ-032 With WARP_SCHED_PERF_EN: 3 accepted issues, then 4 cycles all-stalled -> issue_count=3, stall_count=4; assert reset -> both 0 next cycle.

Source files
------------

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler with per-warp thread-mask scoreboard.
// Optional perf counters enabled by defining WARP_SCHED_PERF_EN.
module warp_issue_scheduler #(
    parameter int NUM_WARPS   = 4,
    parameter int PC_WIDTH    = 8,
    parameter int NUM_THREADS = 32,
    localparam int WID        = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   launch_valid,
    input  logic [WID-1:0]         launch_warp,
    input  logic [PC_WIDTH-1:0]    launch_pc,
    input  logic [NUM_THREADS-1:0] launch_mask,
    input  logic                   mask_write_en,
    input  logic [WID-1:0]         mask_warp,
    input  logic [NUM_THREADS-1:0] mask_in,
    input  logic                   clear_valid,
    input  logic [WID-1:0]         clear_warp,
    input  logic [NUM_THREADS-1:0] clear_mask,
    input  logic                   done_valid,
    input  logic [WID-1:0]         done_warp,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [WID-1:0]         issue_warp,
    output logic [PC_WIDTH-1:0]    issue_pc,
    output logic [NUM_THREADS-1:0] issue_mask,
    output logic [NUM_WARPS-1:0]   active_warps
`ifdef WARP_SCHED_PERF_EN
    ,
    output logic [31:0]            issue_count,
    output logic [31:0]            stall_count
`endif
);

    logic [NUM_WARPS-1:0]                  active;
    logic [NUM_WARPS-1:0][PC_WIDTH-1:0]    pc;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] next_mask;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] pending;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] pend_nxt;
    logic [NUM_WARPS-1:0]                  eligible;
    logic [NUM_WARPS-1:0]                  launch_hit;
    logic [NUM_WARPS-1:0]                  mask_hit;
    logic [NUM_WARPS-1:0]                  done_hit;
    logic [NUM_WARPS-1:0]                  load_hit;
    logic [WID-1:0]                        rr_ptr;
    logic [WID-1:0]                        sel;
    logic [WID-1:0]                        cand;
    logic                                  found;
    logic                                  load_en;
    logic                                  do_load;

    assign active_warps = active;
    assign load_en      = !issue_valid || issue_ready;
    assign do_load      = load_en && found;

    // Eligibility uses registered pending only, so a clear frees a warp one cycle later.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w]   = active[w] && (|next_mask[w])
                            && !(|(pending[w] & next_mask[w]));
            launch_hit[w] = launch_valid && (launch_warp == WID'(w)) && !active[w];
            mask_hit[w]   = mask_write_en && (mask_warp == WID'(w)) && active[w];
            done_hit[w]   = done_valid && (done_warp == WID'(w)) && active[w];
            load_hit[w]   = do_load && (sel == WID'(w));
            pend_nxt[w]   = pending[w];
            if (clear_valid && (clear_warp == WID'(w)))
                pend_nxt[w] = pend_nxt[w] & ~clear_mask;
            if (load_hit[w])
                pend_nxt[w] = pend_nxt[w] | next_mask[w];
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cand = rr_ptr + WID'(i);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active      <= '0;
            pc          <= '0;
            next_mask   <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            issue_valid <= 1'b0;
            issue_warp  <= '0;
            issue_pc    <= '0;
            issue_mask  <= '0;
        end else begin
            if (load_en) begin
                issue_valid <= found;
                if (found) begin
                    issue_warp <= sel;
                    issue_pc   <= pc[sel];
                    issue_mask <= next_mask[sel];
                    rr_ptr     <= sel + 1'b1;
                end
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (launch_hit[w]) begin
                    active[w]    <= 1'b1;
                    pc[w]        <= launch_pc;
                    next_mask[w] <= launch_mask;
                    pending[w]   <= '0;
                end else begin
                    if (mask_hit[w])
                        next_mask[w] <= mask_in;
                    if (load_hit[w])
                        pc[w] <= pc[w] + 1'b1;
                    if (done_hit[w]) begin
                        active[w]  <= 1'b0;
                        pending[w] <= '0;
                    end else begin
                        pending[w] <= pend_nxt[w];
                    end
                end
            end
        end
    end

`ifdef WARP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue_valid && issue_ready)
                issue_count <= issue_count + 32'd1;
            if ((|active) && !(|eligible) && !issue_valid)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: directed vector table, corner sequences
// and randomized traffic checked against a behavioural scoreboard model.
module tb_warp_issue_scheduler;
    localparam int NW = 4;
    localparam int PW = 8;
    localparam int NT = 32;
    localparam logic [NT-1:0] ALL = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          launch_valid;
    logic [1:0]    launch_warp;
    logic [PW-1:0] launch_pc;
    logic [NT-1:0] launch_mask;
    logic          mask_write_en;
    logic [1:0]    mask_warp;
    logic [NT-1:0] mask_in;
    logic          clear_valid;
    logic [1:0]    clear_warp;
    logic [NT-1:0] clear_mask;
    logic          done_valid;
    logic [1:0]    done_warp;
    logic          issue_valid;
    logic          issue_ready;
    logic [1:0]    issue_warp;
    logic [PW-1:0] issue_pc;
    logic [NT-1:0] issue_mask;
    logic [NW-1:0] active_warps;
`ifdef WARP_SCHED_PERF_EN
    logic [31:0]   issue_count;
    logic [31:0]   stall_count;
`endif

    always #5 clk = ~clk;

    warp_issue_scheduler #(.NUM_WARPS(NW), .PC_WIDTH(PW), .NUM_THREADS(NT)) dut (
        .clk(clk), .reset(reset),
        .launch_valid(launch_valid), .launch_warp(launch_warp),
        .launch_pc(launch_pc), .launch_mask(launch_mask),
        .mask_write_en(mask_write_en), .mask_warp(mask_warp), .mask_in(mask_in),
        .clear_valid(clear_valid), .clear_warp(clear_warp), .clear_mask(clear_mask),
        .done_valid(done_valid), .done_warp(done_warp),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_warp(issue_warp), .issue_pc(issue_pc), .issue_mask(issue_mask),
        .active_warps(active_warps)
`ifdef WARP_SCHED_PERF_EN
        , .issue_count(issue_count), .stall_count(stall_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Scoreboard model: warp table plus the issue slot
    bit          m_act [NW];
    int unsigned m_pc  [NW];
    logic [NT-1:0] m_next [NW];
    logic [NT-1:0] m_pend [NW];
    bit          m_iv;
    int          m_iw;
    int unsigned m_ipc;
    logic [NT-1:0] m_imask;
    int          m_ptr;
    int unsigned m_icnt;
    int unsigned m_scnt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit elig(int w);
        return m_act[w] && (m_next[w] != 0) && ((m_pend[w] & m_next[w]) == 0);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_act[w] = 0; m_pc[w] = 0; m_next[w] = 0; m_pend[w] = 0;
        end
        m_iv = 0; m_iw = 0; m_ipc = 0; m_imask = 0; m_ptr = 0;
        m_icnt = 0; m_scnt = 0;
    endtask

    task automatic model_step();
        int sel;
        int best;
        bit any_act;
        bit any_el;
        logic [NT-1:0] p;
        if (reset) begin
            model_reset();
            return;
        end
        sel = -1; best = NW; any_act = 0; any_el = 0;
        for (int w = 0; w < NW; w++) begin
            if (m_act[w]) any_act = 1;
            if (elig(w)) begin
                any_el = 1;
                if ((w - m_ptr + NW) % NW < best) begin
                    best = (w - m_ptr + NW) % NW;
                    sel = w;
                end
            end
        end
        if (m_iv && issue_ready) m_icnt++;
        if (any_act && !any_el && !m_iv) m_scnt++;
        if (!m_iv || issue_ready) begin
            m_iv = (sel >= 0);
            if (sel >= 0) begin
                m_iw = sel; m_ipc = m_pc[sel]; m_imask = m_next[sel];
                m_ptr = (sel + 1) % NW;
            end
        end else begin
            sel = -1;
        end
        for (int w = 0; w < NW; w++) begin
            if (launch_valid && launch_warp == w && !m_act[w]) begin
                m_act[w] = 1; m_pc[w] = launch_pc; m_next[w] = launch_mask; m_pend[w] = 0;
            end else if (m_act[w]) begin
                p = m_pend[w];
                if (clear_valid && clear_warp == w) p = p & ~clear_mask;
                if (sel == w) begin
                    p = p | m_next[w];
                    m_pc[w] = (m_pc[w] + 1) % (1 << PW);
                end
                if (mask_write_en && mask_warp == w) m_next[w] = mask_in;
                if (done_valid && done_warp == w) begin
                    m_act[w] = 0; p = 0;
                end
                m_pend[w] = p;
            end
        end
    endtask

    task automatic check_model();
        logic [NW-1:0] av;
        for (int w = 0; w < NW; w++) av[w] = m_act[w];
        chk("model_active", active_warps, av);
        chk("model_valid", issue_valid, m_iv);
        if (m_iv) begin
            chk("model_warp", issue_warp, m_iw);
            chk("model_pc", issue_pc, m_ipc);
            chk("model_mask", issue_mask, m_imask);
        end
`ifdef WARP_SCHED_PERF_EN
        chk("model_issue_count", issue_count, m_icnt);
        chk("model_stall_count", stall_count, m_scnt);
`endif
    endtask

    task automatic tick();
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        launch_valid = 0; launch_warp = 0; launch_pc = 0; launch_mask = 0;
        mask_write_en = 0; mask_warp = 0; mask_in = 0;
        clear_valid = 0; clear_warp = 0; clear_mask = 0;
        done_valid = 0; done_warp = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic launch(int w, int pcv, logic [NT-1:0] m);
        launch_valid = 1; launch_warp = 2'(w); launch_pc = 8'(pcv); launch_mask = m;
        tick();
        launch_valid = 0;
    endtask

    task automatic wait_issue(string name, int w, int pcv);
        int n;
        n = 0;
        while (!(issue_valid && issue_warp == 2'(w)) && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            checks++; failures++;
            $display("FAIL %s actual=timeout required=warp%0d", name, w);
        end else begin
            chk(name, issue_pc, pcv);
        end
    endtask

    typedef struct {
        bit lv; int lw; int lpc;
        bit cv; int cw;
        bit ev; int ew; int epc;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{1, 0, 'h10, 0, 0, 0, 0, 0};
        vt[1] = '{1, 1, 'h20, 0, 0, 0, 0, 0};
        vt[2] = '{1, 2, 'h30, 0, 0, 1, 0, 'h10};
        vt[3] = '{1, 3, 'h40, 1, 0, 1, 1, 'h20};
        vt[4] = '{0, 0, 0,    1, 1, 1, 2, 'h30};
        vt[5] = '{0, 0, 0,    1, 2, 1, 3, 'h40};
        vt[6] = '{0, 0, 0,    1, 3, 1, 0, 'h11};
        vt[7] = '{0, 0, 0,    0, 0, 1, 1, 'h21};

        idle_inputs();
        issue_ready = 1;
        reset = 1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 0;
        chk("reset_valid", issue_valid, 0);
        chk("reset_warp", issue_warp, 0);
        chk("reset_pc", issue_pc, 0);
        chk("reset_mask", issue_mask, 0);
        chk("reset_active", active_warps, 0);

        // Four warps launched, every issue cleared one cycle later
        for (int i = 0; i < 8; i++) begin
            launch_valid = vt[i].lv; launch_warp = 2'(vt[i].lw);
            launch_pc = 8'(vt[i].lpc); launch_mask = ALL;
            clear_valid = vt[i].cv; clear_warp = 2'(vt[i].cw); clear_mask = ALL;
            chk($sformatf("rr_valid_%0d", i), issue_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk($sformatf("rr_warp_%0d", i), issue_warp, vt[i].ew);
                chk($sformatf("rr_pc_%0d", i), issue_pc, vt[i].epc);
                chk($sformatf("rr_mask_%0d", i), issue_mask, ALL);
            end
            tick();
        end
        idle_inputs();

        // Scoreboard stall: partial clears keep warp 1 blocked
        do_reset();
        launch(1, 0, 32'h0000FFFF);
        tick();
        chk("sb_first_valid", issue_valid, 1);
        chk("sb_first_warp", issue_warp, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sb_stalled", issue_valid, 0);
        end
        clear_valid = 1; clear_warp = 1; clear_mask = 32'h000000FF;
        tick();
        clear_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sb_partial_clear", issue_valid, 0);
        end
        clear_valid = 1; clear_warp = 1; clear_mask = 32'h0000FF00;
        tick();
        clear_valid = 0;
        chk("sb_no_comb_path", issue_valid, 0);
        tick();
        chk("sb_reissue_valid", issue_valid, 1);
        chk("sb_reissue_warp", issue_warp, 1);
        chk("sb_reissue_pc", issue_pc, 1);

        // Backpressure hold, done during hold, reset mid-handshake
        do_reset();
        issue_ready = 0;
        launch(2, 'h50, ALL);
        launch(3, 'h60, ALL);
        chk("hold_warp0", issue_warp, 2);
        for (int i = 0; i < 5; i++) begin
            done_valid = (i == 2); done_warp = 2;
            tick();
            done_valid = 0;
            chk("hold_valid", issue_valid, 1);
            chk("hold_warp", issue_warp, 2);
            chk("hold_pc", issue_pc, 'h50);
            chk("hold_mask", issue_mask, ALL);
        end
        chk("hold_done_active", active_warps, 4'b1000);
        issue_ready = 1;
        tick();
        chk("release_valid", issue_valid, 1);
        chk("release_warp", issue_warp, 3);
        chk("release_pc", issue_pc, 'h60);
        issue_ready = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("midreset_valid", issue_valid, 0);
        chk("midreset_warp", issue_warp, 0);
        chk("midreset_pc", issue_pc, 0);
        chk("midreset_active", active_warps, 0);
        issue_ready = 1;

        // Launch to an active warp is ignored; relaunch after done
        clear_valid = 1; clear_warp = 0; clear_mask = ALL;
        launch(0, 'h10, ALL);
        wait_issue("relaunch_first", 0, 'h10);
        launch(0, 'h77, ALL);
        wait_issue("relaunch_ignored", 0, 'h11);
        done_valid = 1; done_warp = 0;
        tick();
        done_valid = 0;
        launch(0, 'h77, ALL);
        wait_issue("relaunch_new", 0, 'h77);
        idle_inputs();

        // PC wrap on a single warp
        do_reset();
        clear_valid = 1; clear_warp = 3; clear_mask = ALL;
        launch(3, 'hFF, ALL);
        wait_issue("wrap_ff", 3, 'hFF);
        tick();
        wait_issue("wrap_00", 3, 'h00);
        idle_inputs();

`ifdef WARP_SCHED_PERF_EN
        do_reset();
        issue_ready = 1;
        launch(0, 1, ALL);
        launch(1, 2, ALL);
        launch(2, 3, ALL);
        tick();
        tick();
        chk("perf_idle_valid", issue_valid, 0);
        chk("perf_issue_count", issue_count, 3);
        repeat (4) tick();
        chk("perf_stall_count", stall_count, 4);
        reset = 1;
        tick();
        reset = 0;
        chk("perf_reset_issue", issue_count, 0);
        chk("perf_reset_stall", stall_count, 0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            launch_valid = ($urandom_range(0, 3) == 0);
            launch_warp = 2'($urandom);
            launch_pc = 8'($urandom);
            launch_mask = ($urandom_range(0, 7) == 0) ? '0 : NT'($urandom);
            mask_write_en = ($urandom_range(0, 3) == 0);
            mask_warp = 2'($urandom);
            mask_in = ($urandom_range(0, 7) == 0) ? '0 : NT'($urandom);
            clear_valid = ($urandom_range(0, 1) == 0);
            clear_warp = 2'($urandom);
            clear_mask = ($urandom_range(0, 1) == 0) ? ALL : NT'($urandom);
            done_valid = ($urandom_range(0, 19) == 0);
            done_warp = 2'($urandom);
            issue_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
